id_pipe: RTL and testbench

Parametrised, handshaked instruction-decode stage between the fetch stage and the register file / ALU. Splits each instruction into ALU opcode, two source addresses and one destination address. Holds decoded instructions in a two-entry output buffer (output register plus skid register) under valid/ready flow control. Issues a one-cycle register-file read strobe per decoded instruction and, optionally, stalls on register hazards using a destination scoreboard.

---
 rtl/id_pipe.sv | 144 ++++++++++++++
 tb/tb_id_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe.sv
// id_pipe: instruction decode stage, splits an instruction into opcode, two sources and a destination.
// Latency: 1 cycle from accept to out_valid/mem_read when the output register is free or draining.
// Backpressure: a skid register absorbs one extra instruction; in_ready drops while it is full or on a hazard.
// Optional feature macro: ID_SCOREBOARD_EN (destination scoreboard with RAW/WAW hazard stall).
// INST_LEN must equal OP_LEN + 3*ADDR_LEN; any other value is not a legal configuration.

module id_pipe #(
    parameter int OP_LEN   = 2,
    parameter int ADDR_LEN = 5,
    parameter int INST_LEN = OP_LEN + 3 * ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [INST_LEN-1:0] inst,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_LEN-1:0]   alu_sig,
    output logic [ADDR_LEN-1:0] oper1,
    output logic [ADDR_LEN-1:0] oper2,
    output logic [ADDR_LEN-1:0] dest,
    output logic                mem_read,
    input  logic                wb_valid,
    input  logic [ADDR_LEN-1:0] wb_addr
);

    localparam int NREG = 1 << ADDR_LEN;

    // One decoded instruction as held in either buffer slot.
    typedef struct packed {
        logic [OP_LEN-1:0]   op;
        logic [ADDR_LEN-1:0] o1;
        logic [ADDR_LEN-1:0] o2;
        logic [ADDR_LEN-1:0] d;
    } dec_t;

    // Output register (OR) and skid register (SR), each with its own valid bit.
    dec_t r_or;
    logic r_or_vld;
    dec_t r_sr;
    logic r_sr_vld;
    logic r_mem_read;

    dec_t w_in;
    logic w_hazard;
    logic w_accept;
    logic w_drain;
    logic w_load_or_in;
    logic w_load_or_sr;

    // Field split: opcode on top, then oper1, oper2, and dest in the low bits.
    assign w_in.op = inst[INST_LEN-1 -: OP_LEN];
    assign w_in.o1 = inst[3*ADDR_LEN-1 -: ADDR_LEN];
    assign w_in.o2 = inst[2*ADDR_LEN-1 -: ADDR_LEN];
    assign w_in.d  = inst[ADDR_LEN-1:0];

    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_or_vld && out_ready;

    // A new instruction goes straight to OR when OR is free (or freeing) and nothing waits in SR.
    // in_ready already requires SR empty, so an accept never collides with an SR->OR move.
    assign w_load_or_in = w_accept && (!r_or_vld || (w_drain && !r_sr_vld));
    assign w_load_or_sr = w_drain && r_sr_vld;

`ifdef ID_SCOREBOARD_EN
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_eff;

    assign w_set = w_accept ? (NREG'(1) << w_in.d) : '0;
    assign w_clr = wb_valid ? (NREG'(1) << wb_addr) : '0;

    // A write-back in this cycle already frees its register for the hazard check.
    assign w_busy_eff = r_busy & ~w_clr;

    assign w_hazard = in_valid &&
                      (w_busy_eff[w_in.o1] || w_busy_eff[w_in.o2] || w_busy_eff[w_in.d]);

    // Scoreboard update: clear on write-back, then set on accept so a same-address set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end
`else
    logic w_unused_wb;

    // Write-back inputs have no effect without the scoreboard.
    assign w_unused_wb = wb_valid ^ (^wb_addr);
    assign w_hazard    = 1'b0;
`endif

    assign in_ready = !r_sr_vld && !w_hazard;

    // Output register: load from input or from SR, or empty when drained with nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_or_vld <= 1'b0;
            r_or     <= '0;
        end else if (w_load_or_in) begin
            r_or_vld <= 1'b1;
            r_or     <= w_in;
        end else if (w_load_or_sr) begin
            r_or_vld <= 1'b1;
            r_or     <= r_sr;
        end else if (w_drain) begin
            r_or_vld <= 1'b0;
        end
    end

    // Skid register: catches the instruction accepted while OR is stalled, released when OR drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr_vld <= 1'b0;
            r_sr     <= '0;
        end else if (w_accept && !w_load_or_in) begin
            r_sr_vld <= 1'b1;
            r_sr     <= w_in;
        end else if (w_load_or_sr) begin
            r_sr_vld <= 1'b0;
        end
    end

    // Register-file read strobe: one cycle for every instruction that lands in OR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_read <= 1'b0;
        end else begin
            r_mem_read <= w_load_or_in || w_load_or_sr;
        end
    end

    assign out_valid = r_or_vld;
    assign alu_sig   = r_or.op;
    assign oper1     = r_or.o1;
    assign oper2     = r_or.o2;
    assign dest      = r_or.d;
    assign mem_read  = r_mem_read;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: reset, single decode, streaming, backpressure, hazards, mid-run reset.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Hazard expectations follow whether ID_SCOREBOARD_EN is defined for this build.

module tb_id_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [16:0] inst;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  alu_sig;
    logic [4:0]  oper1;
    logic [4:0]  oper2;
    logic [4:0]  dest;
    logic        mem_read;
    logic        wb_valid;
    logic [4:0]  wb_addr;

    int total = 0;
    int bad   = 0;

    id_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inst      (inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_sig   (alu_sig),
        .oper1     (oper1),
        .oper2     (oper2),
        .dest      (dest),
        .mem_read  (mem_read),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input int op, input int a, input int b, input int d);
        logic [16:0] v;
        v = {op[1:0], a[4:0], b[4:0], d[4:0]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        inst      = '0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_addr   = '0;

        // Reset held for two cycles
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu", alu_sig, 0);
        chk("rst_oper1", oper1, 0);
        chk("rst_oper2", oper2, 0);
        chk("rst_dest", dest, 0);
        chk("rst_mem_read", mem_read, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Single instruction 10_00011_00101_01001
        inst     = 17'b10_00011_00101_01001;
        in_valid = 1'b1;
        #1;
        chk("single_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("single_out_valid", out_valid, 1);
        chk("single_alu", alu_sig, 2);
        chk("single_oper1", oper1, 3);
        chk("single_oper2", oper2, 5);
        chk("single_dest", dest, 9);
        chk("single_mem_read", mem_read, 1);
        wb_valid = 1'b1;
        wb_addr  = 5'd9;
        tick();
        wb_valid = 1'b0;
        chk("single_mem_read_off", mem_read, 0);
        chk("single_out_valid_off", out_valid, 0);

        // Streaming: 8 independent instructions back to back
        for (int k = 0; k < 8; k++) begin
            inst     = mk(k % 4, k, k + 8, k + 16);
            in_valid = 1'b1;
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_out_valid", out_valid, 1);
            chk("stream_dest", dest, k + 16);
            chk("stream_oper1", oper1, k);
            chk("stream_alu", alu_sig, k % 4);
            chk("stream_mem_read", mem_read, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_mem_read", mem_read, 0);

        // Backpressure: A, B, C offered with out_ready low
        out_ready = 1'b0;
        inst      = mk(1, 0, 1, 24);
        in_valid  = 1'b1;
        #1;
        chk("bp_a_in_ready", in_ready, 1);
        tick();
        chk("bp_a_out_valid", out_valid, 1);
        chk("bp_a_dest", dest, 24);
        chk("bp_a_mem_read", mem_read, 1);
        inst = mk(2, 0, 1, 25);
        #1;
        chk("bp_b_in_ready", in_ready, 1);
        tick();
        chk("bp_b_dest_hold", dest, 24);
        chk("bp_b_mem_read", mem_read, 0);
        inst = mk(3, 1, 2, 26);
        #1;
        chk("bp_c_blocked", in_ready, 0);
        tick();
        chk("bp_c_still_blocked", in_ready, 0);
        chk("bp_hold_dest", dest, 24);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_out_dest", dest, 25);
        chk("bp_b_out_alu", alu_sig, 2);
        chk("bp_b_out_mem_read", mem_read, 1);
        chk("bp_in_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_out_dest", dest, 26);
        chk("bp_c_out_alu", alu_sig, 3);
        chk("bp_c_out_mem_read", mem_read, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // RAW: X writes r9, Y reads r9
        inst     = mk(0, 1, 2, 9);
        in_valid = 1'b1;
        tick();
        chk("raw_x_dest", dest, 9);
        inst = mk(1, 9, 3, 10);
        #1;
`ifdef ID_SCOREBOARD_EN
        chk("raw_y_stall", in_ready, 0);
        tick();
        chk("raw_y_stall2", in_ready, 0);
        chk("raw_x_gone", out_valid, 0);
        wb_valid = 1'b1;
        wb_addr  = 5'd9;
        #1;
        chk("raw_bypass_ready", in_ready, 1);
`else
        chk("raw_y_no_stall", in_ready, 1);
`endif
        tick();
        wb_valid = 1'b0;
        chk("raw_y_valid", out_valid, 1);
        chk("raw_y_dest", dest, 10);
        chk("raw_y_oper1", oper1, 9);

        // Set/clear collision on r4
        inst     = mk(2, 1, 2, 4);
        wb_valid = 1'b1;
        wb_addr  = 5'd4;
        #1;
        chk("coll_in_ready", in_ready, 1);
        tick();
        wb_valid = 1'b0;
        chk("coll_dest", dest, 4);
        inst = mk(3, 1, 4, 5);
        #1;
`ifdef ID_SCOREBOARD_EN
        chk("coll_stall", in_ready, 0);
`else
        chk("coll_no_stall", in_ready, 1);
`endif

        // Fill OR and SR, then reset mid-operation
        out_ready = 1'b0;
        inst      = mk(1, 1, 2, 27);
        tick();
        in_valid = 1'b0;
        chk("mid_or_dest", dest, 4);
        chk("mid_sr_full", in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_alu", alu_sig, 0);
        chk("mid_oper1", oper1, 0);
        chk("mid_oper2", oper2, 0);
        chk("mid_dest", dest, 0);
        chk("mid_mem_read", mem_read, 0);
        inst     = mk(3, 1, 4, 5);
        in_valid = 1'b1;
        #1;
        chk("mid_in_ready_sb_clear", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("mid_after_valid", out_valid, 1);
        chk("mid_after_dest", dest, 5);
        chk("mid_after_oper2", oper2, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
